i_fetch_decode: RTL and testbench

I_FETCH_DECODE -- requirements
Module: i_fetch_decode

---
 rtl/i_fetch_decode.sv | 115 +++++++++++
 tb/tb_i_fetch_decode.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/i_fetch_decode.sv
// i_fetch_decode: four-state instruction sequencer in front of a registered-read
// instruction memory. Fetches one byte per access and resolves branches (opcode 11)
// internally. Every other word is presented to a consumer through a valid/ready
// handshake. It also keeps a saturating count of accepted instructions.
module i_fetch_decode (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       zero_flag,
  output logic [3:0] imem_addr,
  input  logic [7:0] imem_rdata,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_op,
  output logic [1:0] out_rd,
  output logic [1:0] out_rs,
  output logic [3:0] out_imm,
  output logic [3:0] out_pc,
  output logic       busy,
  output logic [7:0] retired
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;

  localparam logic [1:0] OP_BRANCH = 2'b11;

  logic [1:0] state_reg,   state_next;
  logic [3:0] pc_reg,      pc_next;
  logic [7:0] instr_reg,   instr_next;
  logic [3:0] out_pc_reg,  out_pc_next;
  logic [7:0] retired_reg, retired_next;

  logic       branch_taken;
  logic [3:0] pc_inc;

  assign pc_inc = pc_reg + 4'd1;  // 4-bit add wraps 15 -> 0 naturally

  // Branch condition decode from the cc field of the word arriving in WAIT
  always_comb begin
    branch_taken = 1'b0;
    case (imem_rdata[5:4])
      2'b00:   branch_taken = 1'b1;
      2'b01:   branch_taken = zero_flag;
      2'b10:   branch_taken = ~zero_flag;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state logic; all registers hold unless a transition updates them
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    instr_next   = instr_reg;
    out_pc_next  = out_pc_reg;
    retired_next = retired_reg;
    case (state_reg)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        // Memory captures imem_addr (= pc) on this edge
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rdata[7:6] == OP_BRANCH) begin
          // Branches never reach the consumer; they only redirect pc
          pc_next    = branch_taken ? imem_rdata[3:0] : pc_inc;
          state_next = run ? ST_FETCH : ST_IDLE;
        end else begin
          instr_next  = imem_rdata;
          out_pc_next = pc_reg;
          state_next  = ST_ISSUE;
        end
      end
      default: begin  // ST_ISSUE
        if (out_ready) begin
          pc_next = pc_inc;
          if (retired_reg != 8'hFF) retired_next = retired_reg + 8'd1;
          state_next = run ? ST_FETCH : ST_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= 4'd0;
      instr_reg   <= 8'd0;
      out_pc_reg  <= 4'd0;
      retired_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      out_pc_reg  <= out_pc_next;
      retired_reg <= retired_next;
    end
  end

  assign imem_addr = pc_reg;
  assign out_valid = (state_reg == ST_ISSUE);
  assign busy      = (state_reg != ST_IDLE);
  assign out_op    = instr_reg[7:6];
  assign out_rd    = instr_reg[5:4];
  assign out_rs    = instr_reg[3:2];
  assign out_imm   = instr_reg[3:0];
  assign out_pc    = out_pc_reg;
  assign retired   = retired_reg;

endmodule

// File: tb/tb_i_fetch_decode.sv
// Directed bench for i_fetch_decode with a 16-byte registered-read memory model.
module tb_i_fetch_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       zero_flag;
  logic [3:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_op;
  logic [1:0] out_rd;
  logic [1:0] out_rs;
  logic [3:0] out_imm;
  logic [3:0] out_pc;
  logic       busy;
  logic [7:0] retired;

  logic [7:0] mem [16];
  int total = 0;
  int bad   = 0;

  i_fetch_decode dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .zero_flag  (zero_flag),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_rd     (out_rd),
    .out_rs     (out_rs),
    .out_imm    (out_imm),
    .out_pc     (out_pc),
    .busy       (busy),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; out_ready = 1'b0; zero_flag = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0]  = 8'h43;  // op01 rd00 rs00 imm3
    mem[1]  = 8'h25;  // op00 rd10 rs01
    mem[2]  = 8'h9E;  // op10 rd01 rs11 immE
    mem[3]  = 8'hCD;  // branch always -> 13
    mem[13] = 8'hC8;  // branch always -> 8
    mem[8]  = 8'h11;  // op00 rd01 imm1
    mem[9]  = 8'hCE;  // branch always -> 14
    mem[14] = 8'hDB;  // branch if zero -> 11
    mem[11] = 8'hCE;  // branch always -> 14
    mem[15] = 8'hA7;  // op10 rd10 rs01 imm7 (ordinary word)
    mem[7]  = 8'hF2;  // branch never

    repeat (2) step();
    check("rst_valid", {7'd0, out_valid}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_addr", {4'd0, imem_addr}, 8'd0);
    check("rst_retired", retired, 8'd0);
    check("rst_op", {6'd0, out_op}, 8'd0);
    check("rst_imm", {4'd0, out_imm}, 8'd0);
    check("rst_out_pc", {4'd0, out_pc}, 8'd0);

    rst = 1'b0;
    step();
    check("idle_busy", {7'd0, busy}, 8'd0);

    // First instruction: three edges after run
    run = 1'b1; out_ready = 1'b1;
    step();
    check("fetch_busy", {7'd0, busy}, 8'd1);
    check("fetch_valid", {7'd0, out_valid}, 8'd0);
    step();
    check("wait_valid", {7'd0, out_valid}, 8'd0);
    step();
    check("i0_valid", {7'd0, out_valid}, 8'd1);
    check("i0_op", {6'd0, out_op}, 8'd1);
    check("i0_rd", {6'd0, out_rd}, 8'd0);
    check("i0_imm", {4'd0, out_imm}, 8'd3);
    check("i0_pc", {4'd0, out_pc}, 8'd0);
    step();
    check("i0_retired", retired, 8'd1);
    check("i0_next_addr", {4'd0, imem_addr}, 8'd1);
    check("i0_after_valid", {7'd0, out_valid}, 8'd0);

    // Drop run during WAIT: one issue completes, then IDLE
    step();
    run = 1'b0;
    step();
    check("i1_valid", {7'd0, out_valid}, 8'd1);
    check("i1_rd", {6'd0, out_rd}, 8'd2);
    check("i1_rs", {6'd0, out_rs}, 8'd1);
    check("i1_pc", {4'd0, out_pc}, 8'd1);
    step();
    check("stop_busy", {7'd0, busy}, 8'd0);
    check("stop_valid", {7'd0, out_valid}, 8'd0);
    check("stop_addr", {4'd0, imem_addr}, 8'd2);
    check("stop_retired", retired, 8'd2);
    step();
    check("stop_hold_busy", {7'd0, busy}, 8'd0);

    // Backpressure for five cycles
    run = 1'b1; out_ready = 1'b0;
    repeat (3) step();
    check("bp_valid0", {7'd0, out_valid}, 8'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp_valid_%0d", k), {7'd0, out_valid}, 8'd1);
      check($sformatf("bp_op_%0d", k), {6'd0, out_op}, 8'd2);
      check($sformatf("bp_rd_%0d", k), {6'd0, out_rd}, 8'd1);
      check($sformatf("bp_rs_%0d", k), {6'd0, out_rs}, 8'd3);
      check($sformatf("bp_imm_%0d", k), {4'd0, out_imm}, 8'hE);
      check($sformatf("bp_pc_%0d", k), {4'd0, out_pc}, 8'd2);
      check($sformatf("bp_addr_%0d", k), {4'd0, imem_addr}, 8'd2);
      check($sformatf("bp_ret_%0d", k), retired, 8'd2);
    end
    out_ready = 1'b1;
    step();
    check("bp_retired", retired, 8'd3);
    check("bp_addr", {4'd0, imem_addr}, 8'd3);
    check("bp_after_valid", {7'd0, out_valid}, 8'd0);

    // Unconditional branches 3 -> 13 -> 8
    step();
    step();
    check("br3_addr", {4'd0, imem_addr}, 8'd13);
    check("br3_valid", {7'd0, out_valid}, 8'd0);
    step();
    check("br13_wait_valid", {7'd0, out_valid}, 8'd0);
    step();
    check("br13_addr", {4'd0, imem_addr}, 8'd8);
    check("br13_valid", {7'd0, out_valid}, 8'd0);
    check("br13_retired", retired, 8'd3);
    step();
    step();
    check("i8_valid", {7'd0, out_valid}, 8'd1);
    check("i8_pc", {4'd0, out_pc}, 8'd8);
    check("i8_rd", {6'd0, out_rd}, 8'd1);
    step();
    check("i8_retired", retired, 8'd4);

    // 9 -> 14, then conditional on zero
    step();
    step();
    check("br9_addr", {4'd0, imem_addr}, 8'd14);
    zero_flag = 1'b1;
    step();
    step();
    check("br14_z1_addr", {4'd0, imem_addr}, 8'd11);
    zero_flag = 1'b0;
    step();
    step();
    check("br11_addr", {4'd0, imem_addr}, 8'd14);
    step();
    step();
    check("br14_z0_addr", {4'd0, imem_addr}, 8'd15);

    // Ordinary word at 15, accepted: pc wraps to 0
    mem[0] = 8'hE7;  // branch if not zero -> 7
    step();
    step();
    check("i15_valid", {7'd0, out_valid}, 8'd1);
    check("i15_op", {6'd0, out_op}, 8'd2);
    check("i15_imm", {4'd0, out_imm}, 8'd7);
    check("i15_pc", {4'd0, out_pc}, 8'd15);
    step();
    check("wrap_addr", {4'd0, imem_addr}, 8'd0);
    check("wrap_retired", retired, 8'd5);
    step();
    step();
    check("br0_nz_addr", {4'd0, imem_addr}, 8'd7);
    step();
    step();
    check("br7_never_addr", {4'd0, imem_addr}, 8'd8);

    // Reset in the middle of ISSUE
    step();
    step();
    check("pre_rst_valid", {7'd0, out_valid}, 8'd1);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {7'd0, out_valid}, 8'd0);
    check("mid_rst_addr", {4'd0, imem_addr}, 8'd0);
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    check("mid_rst_out_pc", {4'd0, out_pc}, 8'd0);
    check("mid_rst_retired", retired, 8'd0);
    #3 rst = 1'b0;
    step();
    check("resume_busy", {7'd0, busy}, 8'd1);
    check("resume_addr", {4'd0, imem_addr}, 8'd0);

    // Saturation of the retire counter
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    out_ready = 1'b1;
    repeat (1000) step();
    check("sat_retired", retired, 8'hFF);
    check("sat_busy", {7'd0, busy}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
